// File: rtl/seven_seg_display_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_display_if
// Description : CPU data-output link into the seven-segment display block.
//               The CPU (master) drives dIn/dValid; the display (slave)
//               reports busy while a conversion is in flight.
// Signals     : dIn    [7:0] data word from CPU
//               dValid       level qualifier for dIn
//               busy         conversion in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_display_if;
    logic [7:0] dIn;
    logic       dValid;
    logic       busy;

    modport master (output dIn, output dValid, input busy);
    modport slave  (input dIn, input dValid, output busy);
endinterface
`default_nettype wire

// File: rtl/seven_seg_display.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_display
// Description : Captures an 8-bit CPU result, converts it to sign plus three
//               BCD digits with a sequential double-dabble engine, and drives
//               a 4-digit multiplexed common-anode seven-segment display.
// Parameters  : REFRESH_DIV - clock cycles each digit stays lit (>= 2)
//               SIGNED      - 1: dIn is two's complement, 0: unsigned
// Macro       : LEADING_ZERO_BLANK_EN - when defined, leading zero digits
//               (hundreds, and tens when hundreds is zero) are blanked.
// Ports       : clock  in   system clock, rising edge
//               reset  in   asynchronous active-low reset
//               cpu    slave modport: dIn[7:0], dValid in; busy out
//               seg    out  segments gfedcba, active-low
//               an     out  digit anodes, active-low, an[3] leftmost
//               dp     out  decimal point, active-low, held off
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_display #(
    parameter int REFRESH_DIV = 50_000,
    parameter int SIGNED      = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    seven_seg_display_if.slave   cpu,
    output logic [6:0]           seg,
    output logic [3:0]           an,
    output logic                 dp
);

    localparam int         c_CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_REFRESH_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] c_BLANK   = 7'h7F;
    localparam logic [6:0] c_MINUS   = 7'h3F;
    localparam logic [3:0] c_LAST_IT = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_have;
    logic [7:0]           r_last;
    logic                 r_neg;
    logic [19:0]          r_shift;     // {hundreds, tens, ones, binary}
    logic [3:0]           r_iter;
    logic [6:0]           r_digit [4];

    logic [c_CNT_W-1:0]   r_refresh;
    logic [1:0]           r_scan;
    logic [6:0]           r_seg;
    logic [3:0]           r_an;

    logic                 w_start;
    logic                 w_neg;
    logic [7:0]           w_mag;
    logic [19:0]          w_adj;
    logic [3:0]           w_ones;
    logic [3:0]           w_tens;
    logic [3:0]           w_hund;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = c_BLANK;
        endcase
        return code;
    endfunction

    // A repeat of the last converted value is not reconverted, so a held
    // dValid produces exactly one conversion per distinct value.
    assign w_start = cpu.dValid && (!r_have || (cpu.dIn != r_last));

    // The magnitude of -128 is 128, which still fits in 8 bits, so the
    // double-dabble binary field only needs 8 bits.
    assign w_neg = (SIGNED != 0) && cpu.dIn[7];
    assign w_mag = w_neg ? (~cpu.dIn + 8'd1) : cpu.dIn;

    // Add-3 correction on each BCD nibble ahead of the shift.
    always_comb begin
        w_adj        = r_shift;
        if (r_shift[11:8]  >= 4'd5) w_adj[11:8]  = r_shift[11:8]  + 4'd3;
        if (r_shift[15:12] >= 4'd5) w_adj[15:12] = r_shift[15:12] + 4'd3;
        if (r_shift[19:16] >= 4'd5) w_adj[19:16] = r_shift[19:16] + 4'd3;
    end

    assign w_ones = r_shift[11:8];
    assign w_tens = r_shift[15:12];
    assign w_hund = r_shift[19:16];

    // Conversion FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_have  <= 1'b0;
            r_last  <= 8'd0;
            r_neg   <= 1'b0;
            r_shift <= 20'd0;
            r_iter  <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                r_digit[i] <= c_BLANK;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_last  <= cpu.dIn;
                        r_have  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_neg   <= w_neg;
                        r_shift <= {12'd0, w_mag};
                        r_iter  <= 4'd0;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_shift <= w_adj << 1;
                    r_iter  <= r_iter + 4'd1;
                    if (r_iter == c_LAST_IT) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_digit[0] <= f_seg(w_ones);
`ifdef LEADING_ZERO_BLANK_EN
                    r_digit[1] <= ((w_hund == 4'd0) && (w_tens == 4'd0)) ? c_BLANK : f_seg(w_tens);
                    r_digit[2] <= (w_hund == 4'd0) ? c_BLANK : f_seg(w_hund);
`else
                    r_digit[1] <= f_seg(w_tens);
                    r_digit[2] <= f_seg(w_hund);
`endif
                    r_digit[3] <= r_neg ? c_MINUS : c_BLANK;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Display scan: seg and an are both registered from the same scan index
    // so the anode and its segment pattern always switch on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_refresh <= '0;
            r_scan    <= 2'd0;
            r_seg     <= c_BLANK;
            r_an      <= 4'hF;
        end else begin
            if (r_refresh == c_REFRESH_LAST) begin
                r_refresh <= '0;
                r_scan    <= r_scan + 2'd1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
            r_an  <= ~(4'b0001 << r_scan);
            r_seg <= r_digit[r_scan];
        end
    end

    assign cpu.busy = r_busy;
    assign seg      = r_seg;
    assign an       = r_an;
    assign dp       = 1'b1;

endmodule
`default_nettype wire
